// File: rtl/pipe_skid_register.sv
// Two-entry pipeline register with valid/ready handshake, skid storage and flush.
// All state moves on the falling clock edge. Ready is decoded from registered state only.
//
//   state    | meaning
//   ---------+---------------------------------------------
//   ST_EMPTY | nothing held, out_valid=0, in_ready=1
//   ST_ONE   | head entry in main register, in_ready=1
//   ST_FULL  | head in main, second entry in skid, in_ready=0
module pipe_skid_register #(
    parameter int               WIDTH          = 32,
    parameter logic [WIDTH-1:0] RESET_VALUE    = '0,
    parameter bit               CLEAR_ON_FLUSH = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       count
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             in_fire;
    logic             out_fire;

    assign in_ready  = (state_q != ST_FULL);
    assign out_valid = (state_q != ST_EMPTY);
    assign out_data  = main_q;
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;

    always_comb begin
        count = 2'd0;
        case (state_q)
            ST_ONE:  count = 2'd1;
            ST_FULL: count = 2'd2;
            default: count = 2'd0;
        endcase
    end

    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_EMPTY;
            main_q  <= RESET_VALUE;
            skid_q  <= RESET_VALUE;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            // A same-cycle out_fire has already been taken downstream; only the state is dropped.
            state_d = ST_EMPTY;
            if (CLEAR_ON_FLUSH) begin
                main_d = RESET_VALUE;
            end
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_fire) begin
                        main_d  = in_data;
                        state_d = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (in_fire && out_fire) begin
                        main_d  = in_data;
                    end else if (in_fire) begin
                        skid_d  = in_data;
                        state_d = ST_FULL;
                    end else if (out_fire) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (out_fire) begin
                        main_d  = skid_q;
                        state_d = ST_ONE;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_skid_register.sv
// Bench for pipe_skid_register: directed scenarios plus random traffic against a queue model,
// run on a hold-on-flush instance and a clear-on-flush instance driven by the same inputs.
module tb_pipe_skid_register;

    localparam int          W  = 32;
    localparam logic [31:0] RV = 32'hCAFE_0005;

    logic          clk = 1'b0;
    logic          reset, flush, in_valid, out_ready;
    logic [W-1:0]  in_data;
    logic          h_in_ready, h_out_valid, c_in_ready, c_out_valid;
    logic [W-1:0]  h_out_data, c_out_data;
    logic [1:0]    h_count, c_count;

    int            checks   = 0;
    int            failures = 0;
    logic [W-1:0]  q[$];
    logic [W-1:0]  head_h, head_c;

    always #5 clk = ~clk;

    pipe_skid_register #(.WIDTH(W), .RESET_VALUE(RV), .CLEAR_ON_FLUSH(1'b0)) u_hold (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(h_in_ready), .in_data(in_data),
        .out_valid(h_out_valid), .out_ready(out_ready), .out_data(h_out_data),
        .count(h_count)
    );

    pipe_skid_register #(.WIDTH(W), .RESET_VALUE(RV), .CLEAR_ON_FLUSH(1'b1)) u_clr (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(c_in_ready), .in_data(in_data),
        .out_valid(c_out_valid), .out_ready(out_ready), .out_data(c_out_data),
        .count(c_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%h expected=%h t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        head_h = RV;
        head_c = RV;
    endtask

    // Queue-level view: up to two entries, head shown on out_data, last head retained when empty.
    task automatic model_step();
        bit inf, outf;
        inf  = in_valid && (q.size() < 2);
        outf = (q.size() > 0) && out_ready;
        if (flush) begin
            q.delete();
            head_c = RV;
        end else begin
            if (outf) void'(q.pop_front());
            if (inf)  q.push_back(in_data);
        end
        if (q.size() > 0) begin
            head_h = q[0];
            head_c = q[0];
        end
    endtask

    task automatic check_all(input string tag);
        logic [31:0] n;
        n = q.size();
        chk({tag, "_count_h"}, {30'd0, h_count}, n);
        chk({tag, "_count_c"}, {30'd0, c_count}, n);
        chk({tag, "_in_ready_h"}, {31'd0, h_in_ready}, {31'd0, (n < 2)});
        chk({tag, "_in_ready_c"}, {31'd0, c_in_ready}, {31'd0, (n < 2)});
        chk({tag, "_out_valid_h"}, {31'd0, h_out_valid}, {31'd0, (n > 0)});
        chk({tag, "_out_valid_c"}, {31'd0, c_out_valid}, {31'd0, (n > 0)});
        chk({tag, "_data_h"}, h_out_data, head_h);
        chk({tag, "_data_c"}, c_out_data, head_c);
    endtask

    task automatic cycle(input string tag);
        @(negedge clk);
        model_step();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic drive(input logic f, input logic iv, input logic [W-1:0] d, input logic ordy);
        flush     = f;
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
    endtask

    initial begin
        reset = 1'b1;
        drive(1'b0, 1'b0, '0, 1'b0);
        #1 reset = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset_hold");
        chk("reset_data_const", h_out_data, 32'hCAFE_0005);
        reset = 1'b1;
        cycle("reset_release");

        // Streaming: one entry per cycle, count stays at one.
        for (int i = 1; i <= 4; i++) begin
            drive(1'b0, 1'b1, i, 1'b1);
            cycle("stream");
            chk("stream_data_const", h_out_data, i);
            chk("stream_count_const", {30'd0, h_count}, 32'd1);
        end
        drive(1'b0, 1'b0, '0, 1'b1);
        cycle("stream_drain");

        // Stall into the skid, offered third word ignored.
        drive(1'b0, 1'b1, 32'hA, 1'b0); cycle("stall_a");
        drive(1'b0, 1'b1, 32'hB, 1'b0); cycle("stall_b");
        chk("stall_full_const", {30'd0, h_count}, 32'd2);
        drive(1'b0, 1'b1, 32'hC, 1'b0); cycle("stall_c_ignored");
        chk("stall_head_const", h_out_data, 32'hA);
        drive(1'b0, 1'b0, 32'hx, 1'b1); cycle("drain_1");
        chk("drain_b_const", h_out_data, 32'hB);
        cycle("drain_2");
        chk("drain_empty_const", {30'd0, h_count}, 32'd0);

        // Flush from FULL with a competing input.
        drive(1'b0, 1'b1, 32'h11, 1'b0); cycle("fl_fill1");
        drive(1'b0, 1'b1, 32'h22, 1'b0); cycle("fl_fill2");
        drive(1'b1, 1'b1, 32'h33, 1'b0); cycle("flush_full");
        chk("flush_hold_const", h_out_data, 32'h11);
        chk("flush_clear_const", c_out_data, RV);
        drive(1'b0, 1'b0, 32'hx, 1'b1);
        repeat (3) cycle("flush_after");

        // Flush colliding with an output fire in ONE.
        drive(1'b0, 1'b1, 32'h55, 1'b0); cycle("coll_fill");
        drive(1'b1, 1'b0, 32'hx, 1'b1); cycle("coll_flush");
        drive(1'b0, 1'b0, 32'hx, 1'b1);
        repeat (2) cycle("coll_after");

        // Asynchronous reset while FULL, observed before any clock edge.
        drive(1'b0, 1'b1, 32'h66, 1'b0); cycle("rst_fill1");
        drive(1'b0, 1'b1, 32'h77, 1'b0); cycle("rst_fill2");
        reset = 1'b0;
        #2;
        model_reset();
        check_all("reset_async");
        @(posedge clk);
        reset = 1'b1;
        #1;
        check_all("reset_async_release");

        // Random traffic.
        for (int i = 0; i < 10000; i++) begin
            logic iv;
            iv = ($urandom_range(0, 99) < 65);
            drive(($urandom_range(0, 99) < 4), iv, iv ? $urandom : 32'hx,
                  ($urandom_range(0, 99) < 55));
            cycle("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
